// File: rtl/pong_pixel_scheduler_if.sv
// Requester/screen bundle for the pong pixel scheduler: object requests in, one pixel out.
interface pong_pixel_scheduler_if;
   logic       ball_en;
   logic [3:0] ball_x;
   logic [3:0] ball_y;
   logic       lpad_en;
   logic [3:0] lpad_y;
   logic       rpad_en;
   logic [3:0] rpad_y;
   logic [3:0] x;
   logic [3:0] y;
   logic       pix_valid;
   logic       frame_done;

   modport master (
      output ball_en, ball_x, ball_y, lpad_en, lpad_y, rpad_en, rpad_y,
      input  x, y, pix_valid, frame_done
   );

   modport slave (
      input  ball_en, ball_x, ball_y, lpad_en, lpad_y, rpad_en, rpad_y,
      output x, y, pix_valid, frame_done
   );
endinterface

// File: rtl/pong_pixel_scheduler.sv
// Round-robin pixel scheduler: expands ball and paddles into single pixels, each held for
// DWELL cycles, so the LED matrix shows every object through persistence of vision.
module pong_pixel_scheduler #(
   parameter int DWELL      = 16,
   parameter int DWELLWIDTH = 10,
   parameter int PADLEN     = 4,
   parameter int LCOL       = 0,
   parameter int RCOL       = 15
) (
   input  logic                   clk,
   input  logic                   reset,
   pong_pixel_scheduler_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, BALL, LPAD, RPAD} state_t;

   localparam logic [DWELLWIDTH-1:0] DWELL_LAST = DWELLWIDTH'(DWELL - 1);
   localparam logic [4:0]            PADLEN_W   = 5'(PADLEN);
   localparam logic [3:0]            LCOL_W     = 4'(LCOL);
   localparam logic [3:0]            RCOL_W     = 4'(RCOL);

   state_t                r_state, w_state_nxt, w_target;
   logic [3:0]            r_x, w_x_nxt;
   logic [3:0]            r_y, w_y_nxt;
   logic                  r_pix_valid, w_pix_valid_nxt;
   logic                  r_frame_done, w_frame_done_nxt;
   logic [DWELLWIDTH-1:0] r_dwell, w_dwell_nxt;
   logic [3:0]            r_idx, w_idx_nxt;
   logic [4:0]            r_len, w_len_nxt;
   logic                  w_pix_last;
   logic                  w_enter;

   // First enabled phase after cur in BALL -> LPAD -> RPAD order; IDLE starts the order at BALL.
   function automatic state_t next_phase(state_t cur, logic b, logic l, logic r);
      state_t res;
      res = IDLE;
      case (cur)
         BALL:    if (l) res = LPAD; else if (r) res = RPAD; else if (b) res = BALL;
         LPAD:    if (r) res = RPAD; else if (b) res = BALL; else if (l) res = LPAD;
         default: if (b) res = BALL; else if (l) res = LPAD; else if (r) res = RPAD;
      endcase
      return res;
   endfunction

   // Rows below the screen edge are dropped rather than wrapped.
   function automatic logic [4:0] pad_len(logic [3:0] top);
      logic [4:0] room;
      room = 5'd16 - {1'b0, top};
      return (room < PADLEN_W) ? room : PADLEN_W;
   endfunction

   function automatic logic is_last_phase(state_t s, logic l, logic r);
      logic res;
      case (s)
         BALL:    res = !l && !r;
         LPAD:    res = !r;
         RPAD:    res = 1'b1;
         default: res = 1'b0;
      endcase
      return res;
   endfunction

   // NOTE: every output of this block is assigned a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt     = r_state;
      w_x_nxt         = r_x;
      w_y_nxt         = r_y;
      w_pix_valid_nxt = r_pix_valid;
      w_dwell_nxt     = r_dwell;
      w_idx_nxt       = r_idx;
      w_len_nxt       = r_len;
      w_enter         = 1'b0;
      w_target        = next_phase(r_state, bus.ball_en, bus.lpad_en, bus.rpad_en);
      w_pix_last      = ({1'b0, r_idx} == (r_len - 5'd1));

      if (r_state == IDLE) begin
         w_enter = 1'b1;
      end else if (r_dwell == DWELL_LAST) begin
         if (w_pix_last) begin
            w_enter = 1'b1;
         end else begin
            w_idx_nxt   = r_idx + 4'd1;
            w_y_nxt     = r_y + 4'd1;
            w_dwell_nxt = '0;
         end
      end else begin
         w_dwell_nxt = r_dwell + 1'b1;
      end

      // Coordinates are captured only here, so input changes mid-phase wait for the next entry.
      if (w_enter) begin
         w_state_nxt = w_target;
         w_dwell_nxt = '0;
         w_idx_nxt   = '0;
         case (w_target)
            BALL: begin
               w_x_nxt = bus.ball_x; w_y_nxt = bus.ball_y;
               w_len_nxt = 5'd1; w_pix_valid_nxt = 1'b1;
            end
            LPAD: begin
               w_x_nxt = LCOL_W; w_y_nxt = bus.lpad_y;
               w_len_nxt = pad_len(bus.lpad_y); w_pix_valid_nxt = 1'b1;
            end
            RPAD: begin
               w_x_nxt = RCOL_W; w_y_nxt = bus.rpad_y;
               w_len_nxt = pad_len(bus.rpad_y); w_pix_valid_nxt = 1'b1;
            end
            default: begin
               w_x_nxt = '0; w_y_nxt = '0;
               w_len_nxt = '0; w_pix_valid_nxt = 1'b0;
            end
         endcase
      end

      // Registered pulse: predicted from the cycle being entered so it lines up with the last dwell cycle.
      w_frame_done_nxt = (w_state_nxt != IDLE) && (w_dwell_nxt == DWELL_LAST) &&
                         ({1'b0, w_idx_nxt} == (w_len_nxt - 5'd1)) &&
                         is_last_phase(w_state_nxt, bus.lpad_en, bus.rpad_en);
   end

   // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_x          <= '0;
         r_y          <= '0;
         r_pix_valid  <= 1'b0;
         r_frame_done <= 1'b0;
         r_dwell      <= '0;
         r_idx        <= '0;
         r_len        <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_x          <= w_x_nxt;
         r_y          <= w_y_nxt;
         r_pix_valid  <= w_pix_valid_nxt;
         r_frame_done <= w_frame_done_nxt;
         r_dwell      <= w_dwell_nxt;
         r_idx        <= w_idx_nxt;
         r_len        <= w_len_nxt;
      end
   end

   assign bus.x          = r_x;
   assign bus.y          = r_y;
   assign bus.pix_valid  = r_pix_valid;
   assign bus.frame_done = r_frame_done;

endmodule

// File: doc/pong_pixel_scheduler.md
Name: pong_pixel_scheduler

Overview:
- Time-multiplexes the single-point pixel input of the LED-matrix screen between three requesters: the ball, the left paddle and the right paddle.
- Sits between the game objects and the screen driver, and drives the screen's 4-bit x/y.
- Each object is expanded into its pixels. Each pixel is held for a fixed dwell time, and the block cycles round-robin so that all objects appear lit through persistence of vision.

Parameters:
- DWELL, 16, clock cycles each pixel is presented (min 1).
- DWELLWIDTH, 10, width of the dwell counter; must satisfy 2^DWELLWIDTH >= DWELL.
- PADLEN, 4, paddle length in pixels (1..16).
- LCOL, 0, x column of the left paddle.
- RCOL, 15, x column of the right paddle.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- ball_en  input  1  ball requester active.
- ball_x  input  4  ball column.
- ball_y  input  4  ball row.
- lpad_en  input  1  left paddle requester active.
- lpad_y  input  4  left paddle top row.
- rpad_en  input  1  right paddle requester active.
- rpad_y  input  4  right paddle top row.
- x  output  4  pixel column to screen.
- y  output  4  pixel row to screen.
- pix_valid  output  1  x/y hold a pixel to light.
- frame_done  output  1  one-cycle pulse on the final cycle of a frame.

Behaviour:
- One clock (clk). Reset is synchronous and active-high. All outputs are registered.
- Reset values: state=IDLE, x=0, y=0, pix_valid=0, frame_done=0, dwell counter=0, pixel index=0. Reset asserted mid-operation gives these values on the next edge and abandons any frame in progress.
- States: IDLE, BALL, LPAD, RPAD. The phase order is fixed: BALL -> LPAD -> RPAD -> BALL...
- Phase skipping: disabled requesters are skipped. The enable is sampled only at phase boundaries, i.e. in IDLE or on the last cycle of a phase. Deasserting an enable mid-phase lets that phase complete.
- IDLE:
  - x=y=0 and pix_valid=0.
  - If any enable is high in cycle k, the first enabled phase in order is entered. Its first pixel is on the outputs from edge k+1, giving 1-cycle latency.
  - If no enable is high, stay in IDLE.
- Coordinate latching: coordinates are latched on phase entry (ball_x/ball_y, or the paddle y). Input changes during a phase do not affect the outputs until the next entry of that phase.
- BALL phase: one pixel at (ball_x, ball_y) for DWELL cycles.
- LPAD and RPAD phases:
  - Pixels are (col, top+i) for i = 0 .. effLen-1, where effLen = min(PADLEN, 16-top). It is computed at entry with 5-bit arithmetic.
  - Off-screen rows are never emitted and consume no dwell time. There is no wrap to row 0.
- Dwell timing:
  - Each pixel holds constant x/y with pix_valid=1 for exactly DWELL cycles. Pixel changes are back-to-back, with no gap cycle.
  - When the dwell counter reaches DWELL-1, the block advances to the next pixel, the next phase, or the next frame.
- frame_done:
  - Asserted for exactly one cycle, coinciding with the last dwell cycle of the last pixel of the last enabled phase in the frame.
  - If the only enabled requester is the ball, frame_done pulses every DWELL cycles.
- Next frame / IDLE return:
  - At the end of a frame, if some enable is high, the next frame starts on the next edge with no gap.
  - If all enables are low at the end of a phase, the block returns to IDLE: pix_valid=0 and x=y=0 on the next edge.
- Enable check at a boundary: the next phase is the first enabled one after the current phase in cyclic order.

Test Plan:
- Ball only, DWELL=4, ball=(5,7): from 1 cycle after ball_en, x=5, y=7, pix_valid=1 continuously. frame_done pulses on every 4th cycle.
- All enabled, DWELL=2, PADLEN=4, ball=(8,8), lpad_y=3, rpad_y=10:
  - Pixel sequence: (8,8), (0,3), (0,4), (0,5), (0,6), (15,10), (15,11), (15,12), (15,13), each held 2 cycles.
  - The frame is 18 cycles long; frame_done is high on cycle 18 only.
  - The sequence repeats with no gap.
- lpad_y=14, PADLEN=4, others disabled, DWELL=3: only (0,14) then (0,15) are shown, 3 cycles each. There is never a y=0 pixel, and frame_done fires every 6 cycles.
- ball_x changes 5->9 mid-BALL slot: output stays x=5 through that slot. x=9 appears at the next BALL entry.
- No enables: outputs stay 0 with pix_valid=0. Raising rpad_en at cycle k gives (15,rpad_y) valid at edge k+1. Dropping rpad_en mid-phase completes the paddle, then returns to IDLE.
- Reset asserted during the RPAD phase: x=0, y=0, pix_valid=0, frame_done=0 on the next edge. After release, the block restarts at BALL if ball_en is high.
